// File: rtl/jk_cmd_sequencer.sv
// JK command sequencer: queues {op,cnt} commands in a small FIFO and replays
// each one as a burst of registered en/j/k pulses toward a JK latch.
// Ports: clk, rst (async, active-high), flush (sync clear)
//        cmd_valid/cmd_ready/cmd_op/cmd_cnt : command push side
//        j, k, en, done                     : registered latch drive
//        q_exp                              : predicted latch output
//        busy                               : queue or burst pending
module jk_cmd_sequencer #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_cnt,
  output logic       j,
  output logic       k,
  output logic       en,
  output logic       q_exp,
  output logic       busy,
  output logic       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [3:0]    rem_q, rem_d;
  logic [3:0]    gap_q, gap_d;
  logic          en_q, en_d;
  logic          j_q, j_d;
  logic          k_q, k_d;
  logic          done_q, done_d;
  logic          qx_q, qx_d;
  logic          push, pop;
  logic          full, empty;
  logic [5:0]    head;
  logic [3:0]    head_cnt;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign cmd_ready = !full && !flush;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_q];
  // a count of zero is shorthand for a single issue
  assign head_cnt  = (head[3:0] == 4'd0) ? 4'd1 : head[3:0];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {cmd_op, cmd_cnt};
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    en_d    = 1'b0;
    j_d     = 1'b0;
    k_d     = 1'b0;
    done_d  = 1'b0;
    qx_d    = qx_q;
    pop     = 1'b0;

    // the latch sees the pulse leaving ISSUE, so track it even on flush
    if (state_q == ISSUE) begin
      unique case (op_q)
        2'b01:   qx_d = 1'b0;
        2'b10:   qx_d = 1'b1;
        2'b11:   qx_d = ~qx_q;
        default: qx_d = qx_q;
      endcase
    end

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          op_d       = head[5:4];
          rem_d      = head_cnt;
          state_d    = ISSUE;
          en_d       = 1'b1;
          {j_d, k_d} = head[5:4];
          done_d     = (head_cnt == 4'd1);
        end
      end
      ISSUE: begin
        if (rem_q == 4'd1) begin
          state_d = IDLE;
          rem_d   = 4'd0;
        end else begin
          rem_d = rem_q - 4'd1;
          if (GAP_CYCLES == 0) begin
            en_d       = 1'b1;
            {j_d, k_d} = op_q;
            done_d     = (rem_q == 4'd2);
          end else begin
            state_d = GAP;
            gap_d   = 4'(GAP_CYCLES);
          end
        end
      end
      GAP: begin
        if (gap_q <= 4'd1) begin
          state_d    = ISSUE;
          en_d       = 1'b1;
          {j_d, k_d} = op_q;
          done_d     = (rem_q == 4'd1);
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      pop     = 1'b0;
      rem_d   = 4'd0;
      en_d    = 1'b0;
      j_d     = 1'b0;
      k_d     = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      rem_q   <= 4'd0;
      gap_q   <= 4'd0;
      en_q    <= 1'b0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      done_q  <= 1'b0;
      qx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      en_q    <= en_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      qx_q    <= qx_d;
    end
  end

  assign j     = j_q;
  assign k     = k_q;
  assign en    = en_q;
  assign done  = done_q;
  assign q_exp = qx_q;
  assign busy  = (state_q != IDLE) || !empty;

endmodule

// File: doc/jk_cmd_sequencer.md
JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter GAP_CYCLES, default 1, idle cycles with en=0 between consecutive issues of one burst (0..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous clear of FIFO and current burst.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  sequencer can accept a command this cycle.
REQ-008 cmd_op  input  2  00 HOLD, 01 RESET, 10 SET, 11 TOGGLE (JK encoding {j,k}).
REQ-009 cmd_cnt  input  4  issue count for the command; 0 means 1.
REQ-010 j  output  1  J drive to downstream JK latch.
REQ-011 k  output  1  K drive to downstream JK latch.
REQ-012 en  output  1  enable pulse to downstream JK latch, one cycle per issue.
REQ-013 q_exp  output  1  expected latch output after all issues so far.
REQ-014 busy  output  1  FIFO non-empty or burst in progress.
REQ-015 done  output  1  one-cycle pulse coincident with the last issue of a command.

Function
REQ-016 Command accepted on a rising edge where cmd_valid && cmd_ready; accepted command written to FIFO tail.
REQ-017 cmd_ready SHALL be !full && !flush, derived from the registered FIFO count; no push bypass when full, even if a pop occurs the same edge.
REQ-018 FSM states: IDLE, ISSUE, GAP.
REQ-019 IDLE: if FIFO non-empty, pop head at the edge, load op and remaining = (cnt==0 ? 1 : cnt), go ISSUE; else stay.
REQ-020 ISSUE (exactly one cycle): en=1, {j,k}=op; if remaining==1, done=1 and next state is IDLE; else remaining decrements, next state is GAP, or ISSUE when GAP_CYCLES==0.
REQ-021 GAP: en=0, j=k=0 for GAP_CYCLES cycles, then ISSUE.
REQ-022 j, k, en, done SHALL be registered outputs; in IDLE and GAP they are 0.
REQ-023 Latency: command accepted at edge E0 into an empty FIFO in IDLE produces en=1 in the cycle following edge E1.
REQ-024 Back-to-back commands: ISSUE->IDLE->ISSUE; exactly one en=0 cycle between the last issue of one command and the first issue of the next.
REQ-025 HOLD commands pulse en with j=k=0; q_exp is unchanged.
REQ-026 q_exp updates at the edge ending each ISSUE cycle: 01 -> 0, 10 -> 1, 11 -> ~q_exp, 00 -> q_exp.
REQ-027 Push into an empty FIFO is not visible to IDLE until the following edge (no push-to-pop bypass).
REQ-028 FIFO pointers wrap modulo DEPTH; count range 0..DEPTH; no overflow or underflow under any input sequence.
REQ-029 flush=1 at an edge: FIFO count=0, state=IDLE, en/j/k/done=0 next cycle, q_exp retained; push in the same cycle is dropped.
REQ-030 busy = (state != IDLE) || (count != 0).

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, FIFO empty, remaining=0, j=k=en=done=0, q_exp=0, busy=0, cmd_ready=1 after release.
REQ-032 Reset asserted mid-burst SHALL abort the burst with no further en pulses; the first command accepted after release starts a fresh burst.

Verification
REQ-033 After reset, push SET cnt=0 -> one en pulse with j=1,k=0 one cycle after acceptance, done high in the same cycle, q_exp=1.
REQ-034 GAP_CYCLES=1, push TOGGLE cnt=3 -> en pattern 1,0,1,0,1; q_exp sequence 1,0,1; done only on the third pulse.
REQ-035 Hold en off by pushing 5 commands while DEPTH=4 and the FSM is stalled in a long burst -> cmd_ready=0 after 4 accepted; 5th held until a pop occurs; all 5 issue in order.
REQ-036 Assert flush during the 2nd issue of TOGGLE cnt=4 with 2 queued commands -> no further en pulses, busy=0 next cycle, q_exp retains its value after the 2nd toggle.
REQ-037 Assert rst asynchronously between clock edges during GAP -> en, done, busy, q_exp drop to 0 without waiting for a clock edge; queued commands are lost.
REQ-038 GAP_CYCLES=0, push RESET cnt=2 then HOLD cnt=1 -> en high 2 cycles, one en=0 cycle, en high 1 cycle; q_exp=0 throughout.
